// File: rtl/fte_reader_pkg.sv
// Shared platform constants for the function table (FTE) layout.
// The ROM loader that writes FTEs imports these same constants.
package fte_reader_pkg;

   localparam logic [31:0] DEFAULT_FUNCTION_TABLE_BASE = 32'h0000_1000;
   localparam int unsigned DEFAULT_FTE_BYTES           = 5;

   // Attribute byte (offset 4): {argc[5:0], is_import, is_service}
   localparam int unsigned FTE_SERVICE_BIT = 0;
   localparam int unsigned FTE_IMPORT_BIT  = 1;
   localparam int unsigned FTE_ARGC_LSB    = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_READ,
      ST_RESP
   } fte_state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [5:0]  argc;
      logic        is_import;
      logic        is_service;
   } fte_entry_t;

   function automatic fte_entry_t fte_unpack(input logic [31:0] addr, input logic [7:0] attr);
      fte_entry_t e;
      e.addr       = addr;
      e.argc       = attr[FTE_ARGC_LSB +: 6];
      e.is_import  = attr[FTE_IMPORT_BIT];
      e.is_service = attr[FTE_SERVICE_BIT];
      return e;
   endfunction

endpackage

// File: rtl/fte_reader.sv
// Function-table entry reader: bounds-checks a function index, fetches the
// 5-byte FTE over a byte-wide shared bus, and caches the last entry read.
module fte_reader
   import fte_reader_pkg::*;
#(
   parameter logic [31:0] FUNCTION_TABLE_BASE = DEFAULT_FUNCTION_TABLE_BASE,
   parameter int unsigned FTE_BYTES           = DEFAULT_FTE_BYTES
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  func_count,
   input  logic        req_valid,
   input  logic [7:0]  req_func_id,
   output logic        req_ready,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_addr,
   output logic [5:0]  resp_argc,
   output logic        resp_is_import,
   output logic        resp_is_service,
   output logic        resp_error,
   input  logic        invalidate,
   input  logic        mem_access,
   output logic [31:0] mem_addr,
   output logic        mem_read_en,
   input  logic [7:0]  mem_data_out,
   input  logic        mem_ready
);

   fte_state_e  state, state_nxt;
   logic        run_r;
   logic [7:0]  id_r;
   logic [2:0]  byte_idx;
   logic [31:0] addr_buf;
   logic        rd_en_r;
   logic        cache_valid;
   logic [7:0]  cache_id;
   fte_entry_t  cache_entry;
   fte_entry_t  resp_entry;
   logic        resp_err_r;
   logic [31:0] entry_base;
   logic [31:0] rd_addr;
   logic        is_error, is_hit, rd_done, last_byte;

   assign is_error   = id_r >= func_count;
   assign is_hit     = cache_valid && (cache_id == id_r);
   assign rd_done    = (state == ST_READ) && rd_en_r && mem_access && mem_ready;
   assign last_byte  = byte_idx == 3'd4;
   assign entry_base = FUNCTION_TABLE_BASE + 32'(id_r) * FTE_BYTES;
   assign rd_addr    = entry_base + 32'(byte_idx);

   // The bus is shared; release it whenever we do not hold the grant.
   assign mem_addr    = mem_access ? rd_addr : 'z;
   assign mem_read_en = mem_access ? rd_en_r : 1'bz;

   assign req_ready       = (state == ST_IDLE) && run_r;
   assign resp_valid      = state == ST_RESP;
   assign resp_addr       = resp_entry.addr;
   assign resp_argc       = resp_entry.argc;
   assign resp_is_import  = resp_entry.is_import;
   assign resp_is_service = resp_entry.is_service;
   assign resp_error      = resp_err_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (req_valid && req_ready) state_nxt = ST_CHECK;
         ST_CHECK: state_nxt = (is_error || is_hit) ? ST_RESP : ST_READ;
         ST_READ:  if (rd_done && last_byte) state_nxt = ST_RESP;
         ST_RESP:  if (resp_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_r       <= 1'b0;
         id_r        <= '0;
         byte_idx    <= '0;
         addr_buf    <= '0;
         rd_en_r     <= 1'b0;
         cache_valid <= 1'b0;
         cache_id    <= '0;
         cache_entry <= '0;
         resp_entry  <= '0;
         resp_err_r  <= 1'b0;
      end else begin
         run_r <= 1'b1;
         unique case (state)
            ST_IDLE: if (req_valid && req_ready) id_r <= req_func_id;
            ST_CHECK: begin
               byte_idx <= '0;
               if (is_error) begin
                  resp_entry <= '0;
                  resp_err_r <= 1'b1;
               end else if (is_hit) begin
                  resp_entry <= cache_entry;
                  resp_err_r <= 1'b0;
               end else begin
                  rd_en_r <= 1'b1;
               end
            end
            ST_READ: if (rd_done) begin
               // Address bytes arrive MSB first, so shifting left assembles them.
               if (last_byte) begin
                  rd_en_r     <= 1'b0;
                  resp_entry  <= fte_unpack(addr_buf, mem_data_out);
                  resp_err_r  <= 1'b0;
                  cache_entry <= fte_unpack(addr_buf, mem_data_out);
                  cache_id    <= id_r;
                  cache_valid <= 1'b1;
               end else begin
                  addr_buf <= {addr_buf[23:0], mem_data_out};
                  byte_idx <= byte_idx + 3'd1;
               end
            end
            default: ;
         endcase
         // Placed last so a coinciding cache fill loses to invalidate.
         if (invalidate) cache_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fte_reader.sv
// Directed self-checking bench for fte_reader with a byte-wide memory
// responder supporting per-byte delay, bus-grant drops and spurious ready.
module tb_fte_reader;

   localparam logic [31:0] BASE = 32'h0000_0100;
   localparam logic [31:0] PARK = 32'hA5A5_A5A5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  func_count = 8'd3;
   logic        req_valid = 1'b0;
   logic [7:0]  req_func_id = '0;
   logic        req_ready;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_addr;
   logic [5:0]  resp_argc;
   logic        resp_is_import;
   logic        resp_is_service;
   logic        resp_error;
   logic        invalidate = 1'b0;
   logic        mem_access = 1'b1;
   wire  [31:0] mem_addr;
   wire         mem_read_en;
   logic [7:0]  mem_data_out = '0;
   logic        mem_ready = 1'b0;

   // Parking drivers: only visible when the DUT releases the bus.
   assign mem_addr    = mem_access ? 'z : PARK;
   assign mem_read_en = mem_access ? 1'bz : 1'b0;

   int errors = 0;
   int checks = 0;
   logic [7:0]  mem [256];
   logic [31:0] addr_log [128];
   int n_rd = 0;
   int n_en = 0;
   int rd_delay = 0;
   int rd_cnt = 0;
   logic drop_arm = 1'b0;
   int drop_at = 0;
   int drop_left = 0;
   logic spurious = 1'b0;

   fte_reader #(
      .FUNCTION_TABLE_BASE(BASE),
      .FTE_BYTES(5)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .func_count(func_count),
      .req_valid(req_valid),
      .req_func_id(req_func_id),
      .req_ready(req_ready),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_addr(resp_addr),
      .resp_argc(resp_argc),
      .resp_is_import(resp_is_import),
      .resp_is_service(resp_is_service),
      .resp_error(resp_error),
      .invalidate(invalidate),
      .mem_access(mem_access),
      .mem_addr(mem_addr),
      .mem_read_en(mem_read_en),
      .mem_data_out(mem_data_out),
      .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Bus monitor: counts read-strobe cycles and accepted byte reads.
   always @(posedge clk) begin
      if (mem_access && mem_read_en === 1'b1) begin
         n_en++;
         if (mem_ready) begin
            addr_log[n_rd] = mem_addr;
            n_rd++;
         end
      end
   end

   // Memory responder.
   always @(posedge clk) begin
      #1;
      if (!mem_access) begin
         chk("park_addr", mem_addr, PARK);
         chk("park_rden", 32'(mem_read_en), 32'd0);
      end
      if (drop_left > 0) begin
         drop_left--;
         if (drop_left == 0) mem_access = 1'b1;
      end else if (drop_arm && n_rd == drop_at) begin
         drop_arm   = 1'b0;
         mem_access = 1'b0;
         drop_left  = 2;
      end
      if (!mem_access) begin
         mem_ready    = spurious ? ~mem_ready : 1'b0;
         mem_data_out = 8'hFF;
      end else if (mem_ready) begin
         mem_ready = 1'b0;
         rd_cnt    = 0;
      end else if (mem_read_en === 1'b1) begin
         if (rd_cnt >= rd_delay) begin
            mem_ready    = 1'b1;
            mem_data_out = mem[mem_addr[7:0]];
            rd_cnt       = 0;
         end else begin
            rd_cnt++;
         end
      end else begin
         rd_cnt = 0;
      end
   end

   task automatic lookup(input logic [7:0] id, input int hold,
                         input logic [31:0] e_addr, input logic [5:0] e_argc,
                         input logic e_imp, input logic e_svc, input logic e_err,
                         output int lat, output int nrd, output int nen);
      int rd0, en0;
      rd0 = n_rd;
      en0 = n_en;
      req_func_id = id;
      req_valid   = 1'b1;
      tick;
      req_valid = 1'b0;
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 400) begin
         tick;
         lat++;
      end
      chk("resp_arrives", 32'(resp_valid), 32'd1);
      repeat (hold) tick;
      chk("resp_held", 32'(resp_valid), 32'd1);
      chk("resp_addr", resp_addr, e_addr);
      chk("resp_argc", 32'(resp_argc), 32'(e_argc));
      chk("resp_import", 32'(resp_is_import), 32'(e_imp));
      chk("resp_service", 32'(resp_is_service), 32'(e_svc));
      chk("resp_error", 32'(resp_error), 32'(e_err));
      resp_ready = 1'b1;
      tick;
      resp_ready = 1'b0;
      chk("resp_drops", 32'(resp_valid), 32'd0);
      chk("ready_again", 32'(req_ready), 32'd1);
      nrd = n_rd - rd0;
      nen = n_en - en0;
   endtask

   task automatic chk_addrs(input int r0, input logic [31:0] first);
      for (int i = 0; i < 5; i++) chk("rd_addr", addr_log[r0 + i], first + 32'(i));
   endtask

   initial begin
      int lat, nrd, nen, r0, t;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'h12; mem[8'h01] = 8'h34; mem[8'h02] = 8'h56; mem[8'h03] = 8'h78; mem[8'h04] = 8'hFF;
      mem[8'h05] = 8'h00; mem[8'h06] = 8'h00; mem[8'h07] = 8'h00; mem[8'h08] = 8'h40; mem[8'h09] = 8'h0C;
      mem[8'h0A] = 8'hDE; mem[8'h0B] = 8'hAD; mem[8'h0C] = 8'hBE; mem[8'h0D] = 8'hEF; mem[8'h0E] = 8'h09;

      // Reset state
      tick; tick;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_addr", resp_addr, 32'd0);
      chk("rst_rden", 32'(mem_read_en), 32'd0);
      rst_n = 1'b1;
      chk("rel_req_ready_low", 32'(req_ready), 32'd0);
      tick;
      chk("rel_req_ready_high", 32'(req_ready), 32'd1);

      // id=1 miss: five reads from 0x105
      r0 = n_rd;
      lookup(8'd1, 0, 32'h40, 6'd3, 1'b0, 1'b0, 1'b0, lat, nrd, nen);
      chk("miss1_reads", 32'(nrd), 32'd5);
      chk_addrs(r0, 32'h105);

      // id=1 hit, response held 2 extra cycles
      lookup(8'd1, 2, 32'h40, 6'd3, 1'b0, 1'b0, 1'b0, lat, nrd, nen);
      chk("hit_latency", 32'(lat), 32'd2);
      chk("hit_rden_cycles", 32'(nen), 32'd0);

      // id=3 out of range
      lookup(8'd3, 0, 32'h0, 6'd0, 1'b0, 1'b0, 1'b1, lat, nrd, nen);
      chk("err_latency", 32'(lat), 32'd2);
      chk("err_rden_cycles", 32'(nen), 32'd0);

      // Error response must leave the cache intact
      lookup(8'd1, 0, 32'h40, 6'd3, 1'b0, 1'b0, 1'b0, lat, nrd, nen);
      chk("hit_after_err", 32'(nen), 32'd0);

      // id=0: all flag bits set
      r0 = n_rd;
      lookup(8'd0, 0, 32'h1234_5678, 6'd63, 1'b1, 1'b1, 1'b0, lat, nrd, nen);
      chk("id0_reads", 32'(nrd), 32'd5);
      chk_addrs(r0, 32'h100);

      // Slow memory with a grant drop and spurious ready mid-entry
      rd_delay = 3;
      spurious = 1'b1;
      drop_at  = n_rd + 2;
      drop_arm = 1'b1;
      r0 = n_rd;
      lookup(8'd1, 0, 32'h40, 6'd3, 1'b0, 1'b0, 1'b0, lat, nrd, nen);
      chk("slow_reads", 32'(nrd), 32'd5);
      chk("drop_happened", 32'(drop_arm), 32'd0);
      chk_addrs(r0, 32'h105);
      rd_delay = 0;
      spurious = 1'b0;

      // Reset after the 2nd byte of id=2
      r0 = n_rd;
      req_func_id = 8'd2;
      req_valid   = 1'b1;
      tick;
      req_valid = 1'b0;
      t = 0;
      while (n_rd < r0 + 2 && t < 200) begin
         tick;
         t++;
      end
      chk("rst_mid_bytes", 32'(n_rd - r0), 32'd2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rden", 32'(mem_read_en), 32'd0);
      chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("mid_rst_resp_addr", resp_addr, 32'd0);
      tick;
      rst_n = 1'b1;
      tick;
      chk("mid_rst_ready", 32'(req_ready), 32'd1);
      r0 = n_rd;
      repeat (4) tick;
      chk("no_partial_resp", 32'(resp_valid), 32'd0);
      chk("no_reads_after_rst", 32'(n_rd - r0), 32'd0);
      r0 = n_rd;
      lookup(8'd2, 0, 32'hDEAD_BEEF, 6'd2, 1'b0, 1'b1, 1'b0, lat, nrd, nen);
      chk("reread_reads", 32'(nrd), 32'd5);
      chk_addrs(r0, 32'h10A);

      // invalidate between two id=1 lookups
      lookup(8'd1, 0, 32'h40, 6'd3, 1'b0, 1'b0, 1'b0, lat, nrd, nen);
      chk("inv_fill_reads", 32'(nrd), 32'd5);
      lookup(8'd1, 0, 32'h40, 6'd3, 1'b0, 1'b0, 1'b0, lat, nrd, nen);
      chk("inv_prehit_reads", 32'(nrd), 32'd0);
      invalidate = 1'b1;
      tick;
      invalidate = 1'b0;
      r0 = n_rd;
      lookup(8'd1, 0, 32'h40, 6'd3, 1'b0, 1'b0, 1'b0, lat, nrd, nen);
      chk("inv_reread_reads", 32'(nrd), 32'd5);
      chk_addrs(r0, 32'h105);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
